// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard and flow control for a short in-order pipeline. A per-register
//   scoreboard detects read-after-write hazards on the instruction in ID.
//   A small controller then decides whether the ID instruction may issue,
//   or whether the front end must stall, bubble or flush.
//
//   Control priority, except in HALT: taken branch > halt request > RAW hazard.
//   HALT holds the front end frozen until halt_req drops.
//
//   Optional build macro HAZARD_STATS_EN:
//     adds saturating stall_cnt / flush_cnt statistics outputs.
//
//   Handshake: no valid/ready pairs. id_valid qualifies the ID contents.
//   issue is the single "instruction advances" strobe for the current cycle.
//
//   Outputs are combinational from state and inputs. They are forced low
//   while reset is asserted.
module pipeline_hazard_ctrl #(
    parameter int NREG   = 8,
    parameter int WB_LAT = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            id_valid,
    input  logic [$clog2(NREG)-1:0]         id_rs1,
    input  logic [$clog2(NREG)-1:0]         id_rs2,
    input  logic                            id_rs1_used,
    input  logic                            id_rs2_used,
    input  logic [$clog2(NREG)-1:0]         id_rd,
    input  logic                            id_wr,
    input  logic                            ex_branch_taken,
    input  logic                            halt_req,
    output logic                            issue,
    output logic                            if_stall,
    output logic                            id_bubble,
    output logic                            flush,
    output logic [1:0]                      state
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]                     stall_cnt,
    output logic [15:0]                     flush_cnt
`endif
);

    localparam int AW = $clog2(NREG);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] busy_q [NREG];

    logic issue_c;
    logic if_stall_c;
    logic id_bubble_c;
    logic flush_c;
    logic rs1_busy;
    logic rs2_busy;
    logic hazard;

    // RAW hazard: a source that is actually read is still waiting for write-back
    always_comb begin
        rs1_busy = (busy_q[id_rs1] != 2'd0);
        rs2_busy = (busy_q[id_rs2] != 2'd0);
        hazard   = id_valid & ((id_rs1_used & rs1_busy) | (id_rs2_used & rs2_busy));
    end

    // Priority decision and next state; HALT ignores branches entirely
    always_comb begin
        issue_c     = 1'b0;
        if_stall_c  = 1'b0;
        id_bubble_c = 1'b0;
        flush_c     = 1'b0;
        state_d     = state_q;
        if (state_q == ST_HALT) begin
            if_stall_c  = 1'b1;
            id_bubble_c = 1'b1;
            state_d     = halt_req ? ST_HALT : ST_RUN;
        end else if (ex_branch_taken) begin
            // The ID instruction is wrong-path as well, so it is not allowed into EX
            flush_c     = 1'b1;
            id_bubble_c = 1'b1;
            state_d     = ST_FLUSH;
        end else if (halt_req) begin
            if_stall_c  = 1'b1;
            id_bubble_c = 1'b1;
            state_d     = ST_HALT;
        end else if (state_q == ST_FLUSH) begin
            // ID holds the squashed fetch this cycle: insert one bubble
            id_bubble_c = 1'b1;
            state_d     = ST_RUN;
        end else if (hazard) begin
            if_stall_c  = 1'b1;
            id_bubble_c = 1'b1;
            state_d     = ST_STALL;
        end else begin
            issue_c     = id_valid;
            state_d     = ST_RUN;
        end
    end

    // Outputs are held low for as long as reset is asserted
    always_comb begin
        issue     = issue_c & reset;
        if_stall  = if_stall_c & reset;
        id_bubble = id_bubble_c & reset;
        flush     = flush_c & reset;
        state     = state_q;
    end

    // Controller state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Scoreboard: reload on issue with write; otherwise count down to readable
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                busy_q[i] <= 2'd0;
            end
        end else begin
            busy_q[0] <= 2'd0;
            for (int i = 1; i < NREG; i++) begin
                if (issue_c && id_wr && (id_rd == AW'(i))) begin
                    busy_q[i] <= 2'(WB_LAT);
                end else if (busy_q[i] != 2'd0) begin
                    busy_q[i] <= busy_q[i] - 2'd1;
                end
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic hazard_stall;

    // A stall outside HALT that is not a halt entry can only come from a hazard
    always_comb begin
        hazard_stall = if_stall_c & (state_q != ST_HALT) & ~halt_req;
    end

    // Saturating event counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (hazard_stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (flush_c && (flush_cnt != 16'hFFFF)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter NREG, default 8, meaning the number of architectural registers (address width 3).
REQ-002 SHALL have parameter WB_LAT, default 2, legal range 1..3, meaning the cycles from issue until the result is readable from reg_file.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port id_valid  in  1  a valid instruction sits in ID.
REQ-006 SHALL have ports id_rs1, id_rs2  in  3  ID source register addresses.
REQ-007 SHALL have ports id_rs1_used, id_rs2_used  in  1  the corresponding source is actually read.
REQ-008 SHALL have port id_rd  in  3  ID destination address; id_wr  in  1  the instruction writes id_rd.
REQ-009 SHALL have port ex_branch_taken  in  1  the EX stage resolved a taken branch this cycle.
REQ-010 SHALL have port halt_req  in  1  external request to freeze the pipeline.
REQ-011 SHALL have port issue  out  1  the ID instruction advances to EX this cycle.
REQ-012 SHALL have port if_stall  out  1  hold PC and the IF/ID register.
REQ-013 SHALL have port id_bubble  out  1  load a NOP into ID/EX.
REQ-014 SHALL have port flush  out  1  clear IF/ID (squash the wrong-path fetch).
REQ-015 SHALL have port state  out  2  RUN=0, STALL=1, FLUSH=2, HALT=3.

Function
REQ-016 SHALL keep one 2-bit busy counter per register; a register is busy when its counter is nonzero.
REQ-017 SHALL load busy[id_rd] with WB_LAT when issue & id_wr & id_rd!=0; register 0 SHALL never be busy.
REQ-018 SHALL decrement every other nonzero counter by 1 per cycle; a reload on the same register in the same cycle SHALL take priority over its decrement.
REQ-019 SHALL compute hazard = id_valid & ((id_rs1_used & busy[id_rs1]) | (id_rs2_used & busy[id_rs2])) combinationally.
REQ-020 SHALL give priority ex_branch_taken > halt_req > hazard in every state except HALT.
REQ-021 SHALL assert flush=1, issue=0 and if_stall=0 in any cycle with ex_branch_taken=1 while not in HALT; the next state SHALL be FLUSH.
REQ-022 SHALL last exactly one cycle in FLUSH, with issue=0 and id_bubble=1; the next state SHALL be RUN unless a branch or halt arrives.
REQ-023 SHALL, in RUN or STALL with halt_req=1 and no branch, drive if_stall=1, id_bubble=1 and issue=0, and move to HALT.
REQ-024 SHALL hold if_stall=1, id_bubble=1 and issue=0 in HALT, ignoring ex_branch_taken, and return to RUN the cycle after halt_req=0.
REQ-025 SHALL, in RUN or STALL with hazard=1 and no branch or halt, drive if_stall=1, id_bubble=1 and issue=0, and enter or remain in STALL.
REQ-026 SHALL, in RUN or STALL with no branch, halt or hazard, drive issue=id_valid and return to RUN; the outputs SHALL be combinational from state and inputs.

Reset
REQ-027 SHALL, while reset=0, immediately force state=RUN, clear all busy counters and drive issue, if_stall, id_bubble and flush to 0, independent of clk.
REQ-028 SHALL, on reset assertion mid-STALL or mid-HALT, discard the pending stall or halt; the first cycle after release SHALL behave as RUN with an empty scoreboard.

Configuration
REQ-029 SHALL, with HAZARD_STATS_EN defined, add outputs stall_cnt[15:0] (+1 per cycle of hazard-caused if_stall) and flush_cnt[15:0] (+1 per cycle with flush=1); both SHALL saturate at 16'hFFFF and clear on reset.
REQ-030 SHALL, without HAZARD_STATS_EN, have neither those ports nor the counter logic; all other behaviour SHALL be identical.

Verification (WB_LAT=2, HAZARD_STATS_EN defined)
REQ-031 SHALL cover reset: reset=0 with random inputs -> state=0, issue=if_stall=id_bubble=flush=0, stall_cnt=flush_cnt=0.
REQ-032 SHALL cover RAW: cycle 0 issue rd=3 wr=1; cycles 1..3 present rs1=3 used -> cycles 1-2 if_stall=1, state=STALL; cycle 3 issue=1, state=RUN; stall_cnt=2.
REQ-033 SHALL cover r0: issue rd=0 wr=1, then rs1=0 used -> issue=1 with no stall cycle.
REQ-034 SHALL cover branch during stall: hazard active and ex_branch_taken=1 -> that cycle flush=1, issue=0; next cycle state=FLUSH, id_bubble=1; then RUN; flush_cnt=1, stall_cnt not incremented for that cycle.
REQ-035 SHALL cover halt: halt_req=1 for 3 cycles with a branch pulse in the 2nd -> state=HALT, flush=0 throughout; RUN one cycle after halt_req=0.
REQ-036 SHALL cover reset mid-STALL: reset pulse with busy[3]=2 -> after release, rs1=3 used issues immediately.
